// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch widths, reset vector and the opcode
// field position that decode also relies on.
package cpu_defs;
  localparam int AWIDTH = 12;
  localparam int DWIDTH = 16;
  localparam logic [AWIDTH-1:0] RESET_VECTOR = 12'h000;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

  function automatic opcode_t opcode(input logic [DWIDTH-1:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer; head is a register so outputs stay glitch-free.
// Flush beats push and pop; count feeds the fetch credit check.
module fetch_fifo #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] tail;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM issue, 2-entry buffer, redirect/flush.
// Optional bubble counter port stall_cnt enabled by FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter int AWIDTH = cpu_defs::AWIDTH,
  parameter int DWIDTH = cpu_defs::DWIDTH,
  parameter logic [AWIDTH-1:0] RESET_VECTOR = cpu_defs::RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  output logic              rom_en,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_addr,
  output logic              inst_valid,
  output logic [DWIDTH-1:0] inst,
  output logic [AWIDTH-1:0] inst_pc,
  input  logic              inst_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int W = AWIDTH + DWIDTH;

  logic [AWIDTH-1:0] pc;
  logic [AWIDTH-1:0] if_pc;
  logic              inflight;
  logic              kill;
  logic              pop;
  logic              push;
  logic              issue;
  logic [1:0]        count;
  logic [2:0]        credit;
  logic [W-1:0]      head;

  assign pop    = inst_valid && inst_ready;
  assign credit = {1'b0, count} + {2'b0, inflight};
  // a redirect empties everything, so it never needs credit
  assign issue  = !rst && en_in &&
                  (redirect_valid || (credit < 3'd2 + {2'b0, pop}));
  assign rom_en   = issue;
  assign rom_addr = (issue && redirect_valid) ? redirect_addr : pc;
  assign push     = inflight && !kill && !redirect_valid;

  fetch_fifo #(.W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({rom_data, if_pc}),
    .head  (head),
    .count (count)
  );

  assign inst_valid     = (count != 2'd0);
  assign {inst, inst_pc} = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      if_pc    <= '0;
      inflight <= 1'b0;
      kill     <= 1'b1;
    end else begin
      kill     <= 1'b0;
      inflight <= issue;
      if (issue) if_pc <= rom_addr;
      if (redirect_valid)
        pc <= en_in ? redirect_addr + AWIDTH'(1) : redirect_addr;
      else if (issue)
        pc <= pc + AWIDTH'(1);
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (en_in && !inst_valid) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC stream per redirect/reset,
// monitor pops and compares on every accepted instruction.
module tb_fetch_unit;
  typedef struct {
    logic [11:0] pc;
    logic [15:0] w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [15:0] rom_data = 16'h0;
  logic        redirect_valid;
  logic [11:0] redirect_addr;
  logic        inst_valid;
  logic [15:0] inst;
  logic [11:0] inst_pc;
  logic        inst_ready;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_exp;
`endif

  logic [15:0] rom [4096];
  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        held = 1'b0;
  logic [15:0] h_inst;
  logic [11:0] h_pc;
  logic        armed = 1'b0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .en_in          (en_in),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rom_en) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // expected delivery: consecutive addresses from the new start point
  task automatic restart(input logic [11:0] a);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      e.pc = 12'(a + 12'(i));
      e.w  = rom[e.pc];
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_chk(input logic [11:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    restart(a);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_r1_valid", inst_valid, 1'b0);
    step();
    @(negedge clk);
    check("redir_r2_valid", inst_valid, 1'b1);
    check("redir_r2_pc", inst_pc, a);
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst || !armed) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", inst_valid, 1'b1);
        check("hold_inst", inst, h_inst);
        check("hold_pc", inst_pc, h_pc);
      end
      if (!en_in) check("en_low_rom_en", rom_en, 1'b0);
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("queue_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", inst_pc, e.pc);
          check("pop_inst", inst, e.w);
        end
      end
      held   = inst_valid && !inst_ready && !redirect_valid;
      h_inst = inst;
      h_pc   = inst_pc;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always @(posedge clk)
    if (rst) stall_exp <= 32'd0;
    else if (en_in && !inst_valid) stall_exp <= stall_exp + 32'd1;

  always @(negedge clk)
    if (armed) check("stall_cnt", stall_cnt, stall_exp);
`endif

  initial begin
    logic [11:0] last;
    int n;
    rst = 1'b1;
    en_in = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 12'h0;
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h1100;
    rom[1] = 16'h2200;
    rom[2] = 16'h3300;
    rom[3] = 16'h4400;
    restart(12'h000);
    step();
    step();
    @(negedge clk);
    armed = 1'b1;
    check("rst_valid", inst_valid, 1'b0);
    check("rst_rom_en", rom_en, 1'b0);
    check("rst_inst", inst, 16'h0);
    check("rst_inst_pc", inst_pc, 12'h0);
    step();
    rst = 1'b0;

    // first fetches and 2-cycle latency
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("start_rom_en", rom_en, 1'b1);
      check("start_rom_addr", rom_addr, 12'(k));
      check("start_valid", inst_valid, k >= 2);
      if (k >= 2) begin
        check("start_pc", inst_pc, 12'(k - 2));
        check("start_inst", inst, rom[k-2]);
      end
      step();
    end

    // back-pressure: buffer fills, issue stops
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 1) check("bp_rom_en", rom_en, 1'b0);
      step();
    end
    inst_ready = 1'b1;
    repeat (6) step();

    // redirect while 0x005 is in flight
    rst = 1'b1;
    restart(12'h000);
    step();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rom_en && rom_addr == 12'h005) begin
        n = 1;
        break;
      end
      step();
    end
    check("find_issue_5", n, 1);
    step();
    redirect_chk(12'h080);

    // address wrap
    redirect_chk(12'hFFE);
    n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) n++;
      step();
    end
    check("wrap_pops", n, 3);

    // enable drop with a read in flight
    @(negedge clk);
    check("pre_drop_rom_en", rom_en, 1'b1);
    last = rom_addr;
    step();
    en_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drop_rom_en", rom_en, 1'b0);
      step();
    end
    en_in = 1'b1;
    @(negedge clk);
    check("resume_rom_en", rom_en, 1'b1);
    check("resume_addr", rom_addr, 12'(last + 12'd1));
    step();
    repeat (4) step();

    // single-cycle reset mid-stream
    rst = 1'b1;
    restart(12'h000);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst2_valid", inst_valid, 1'b0);
    check("rst2_rom_en", rom_en, 1'b1);
    check("rst2_addr", rom_addr, 12'h000);
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [11:0] a;
      inst_ready = ($urandom_range(0, 3) != 0);
      en_in      = ($urandom_range(0, 7) != 0);
      redirect_valid = 1'b0;
      rst = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        a = 12'($urandom);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        restart(a);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        restart(12'h000);
      end
      step();
    end

    // drain: progress must resume under full enable
    rst = 1'b0;
    redirect_valid = 1'b0;
    en_in = 1'b1;
    inst_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clk);
      if (inst_valid) n = 1;
      step();
    end
    check("drain_progress", n, 1);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
